rv32i_if_top: RTL
=================

RV32I_IF_TOP -- requirements
Module: rv32i_if_top

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, byte address fetched first after reset.
REQ-002 SHALL have parameter: NOP_IW, 32'h00000013, instruction word presented as a bubble (ADDI x0,x0,0).
REQ-003 SHALL have port: clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
REQ-005 SHALL have port: stall_in  input  1  downstream decode stage cannot accept; hold pc_out/iw_out.
REQ-006 SHALL have port: jmp_en_in  input  1  redirect request from execute stage (taken branch/jump).
REQ-007 SHALL have port: jmp_addr_in  input  32  redirect target byte address.
REQ-008 SHALL have port: imem_req  output  1  instruction memory read strobe (combinational).
REQ-009 SHALL have port: imem_addr  output  32  word-aligned byte address of read (combinational, = fetch PC).
REQ-010 SHALL have port: imem_rdata  input  32  read data, valid exactly one cycle after the cycle imem_req=1.
REQ-011 SHALL have port: pc_out  output  32  registered PC of iw_out, to decode stage.
REQ-012 SHALL have port: iw_out  output  32  registered instruction word, to decode stage.
REQ-013 SHALL have port: halted  output  1  registered; 1 after EBREAK issued.

Function
REQ-014 SHALL hold internal state: fetch_pc[31:0], req_valid, req_pc[31:0], hold_valid, hold_iw[31:0], hold_pc[31:0], halted.
REQ-015 SHALL drive imem_req = reset & ~halted & ~stall_in & ~jmp_en_in; imem_addr = fetch_pc at all times.
REQ-016 SHALL, on a cycle with imem_req=1, set fetch_pc <= fetch_pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0), req_valid <= 1, req_pc <= fetch_pc; otherwise req_valid <= 0.
REQ-017 SHALL, when stall_in=1, jmp_en_in=0 and req_valid=1, capture hold_iw <= imem_rdata, hold_pc <= req_pc, hold_valid <= 1; pc_out/iw_out unchanged.
REQ-018 SHALL, when stall_in=0 and jmp_en_in=0, load outputs with priority: hold_valid -> (hold_pc, hold_iw), clear hold_valid; else req_valid -> (req_pc, imem_rdata); else iw_out <= NOP_IW, pc_out unchanged.
REQ-019 SHALL never have hold_valid and req_valid both 1 (at most one outstanding read); the one-entry hold buffer SHALL be sufficient, with no instruction lost or duplicated across any stall pattern.
REQ-020 SHALL, on jmp_en_in=1 (priority over stall_in), set fetch_pc <= {jmp_addr_in[31:2],2'b00}, clear req_valid and hold_valid, set iw_out <= NOP_IW, pc_out unchanged; returning data for the squashed request SHALL be discarded.
REQ-021 SHALL meet redirect latency: jmp_en_in in cycle N -> imem_req with target in N+1 -> target instruction on iw_out from cycle N+3 (two bubbles).
REQ-022 SHALL set halted <= 1 on the edge that loads 32'h00100073 (EBREAK) into iw_out; EBREAK itself SHALL be delivered to decode.
REQ-023 SHALL, while halted=1, issue no reads, ignore jmp_en_in, discard any in-flight read data, and load iw_out <= NOP_IW whenever stall_in=0.
REQ-024 SHALL leave halted set until reset; an EBREAK captured in hold buffer SHALL set halted only when it reaches iw_out.
REQ-025 SHALL have steady-state throughput of one instruction per cycle with stall_in=0, first valid iw_out two cycles after reset release.

Reset
REQ-026 SHALL, on posedge clk with reset=0: fetch_pc <= RESET_PC, pc_out <= RESET_PC, iw_out <= NOP_IW, req_valid/hold_valid/halted <= 0; imem_req=0 during reset.
REQ-027 SHALL on reset mid-operation discard outstanding read and hold buffer contents; first read after release SHALL be at RESET_PC.

Verification
REQ-028 SHALL cover: release reset, memory word[i]=0x100+i, no stall -> imem_addr 0,4,8,...; iw_out 0x100,0x101,... from 2nd cycle after release, pc_out matching.
REQ-029 SHALL cover: stall_in=1 for 3 cycles in steady flow -> iw_out frozen, no imem_req, after release next PCs resume in order with no gap beyond one cycle, none skipped/duplicated.
REQ-030 SHALL cover: jmp_en_in=1, jmp_addr_in=0x0000_0203 -> NOP for two cycles, then pc_out=0x200 with word at 0x200; stale sequential word never appears.
REQ-031 SHALL cover: jmp_en_in and stall_in both 1 -> iw_out=NOP_IW, hold cleared, fetch resumes at target once stall drops.
REQ-032 SHALL cover: 0x00100073 at address 0x10 -> iw_out=0x00100073 pc_out=0x10, halted=1 next, thereafter imem_req=0 and iw_out=NOP_IW; jmp_en_in ignored; reset=0 clears halt.
REQ-033 SHALL cover: RESET_PC=0xFFFFFFF8 -> fetch 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).

Source files
------------

// File: rtl/rv32i_if_top.sv
// RV32I instruction fetch stage: sequential PC generation, one outstanding read,
// one-entry hold buffer for downstream stalls, redirect squash and EBREAK halt.
module rv32i_if_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IW   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        jmp_en_in,
  input  logic [31:0] jmp_addr_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic        halted
);

  localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

  logic [31:0] fetch_pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        hold_valid;
  logic [31:0] hold_iw;
  logic [31:0] hold_pc;

  logic        load_en;
  logic [31:0] load_pc;
  logic [31:0] load_iw;

  assign imem_req  = reset & ~halted & ~stall_in & ~jmp_en_in;
  assign imem_addr = fetch_pc;

  // Held instruction is older than any in-flight read, so it drains first.
  always_comb begin
    load_en = 1'b0;
    load_pc = pc_out;
    load_iw = NOP_IW;
    if (hold_valid) begin
      load_en = 1'b1;
      load_pc = hold_pc;
      load_iw = hold_iw;
    end else if (req_valid) begin
      load_en = 1'b1;
      load_pc = req_pc;
      load_iw = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      req_valid  <= 1'b0;
      req_pc     <= '0;
      hold_valid <= 1'b0;
      hold_iw    <= NOP_IW;
      hold_pc    <= '0;
      pc_out     <= RESET_PC;
      iw_out     <= NOP_IW;
      halted     <= 1'b0;
    end else begin
      req_valid <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end

      if (halted) begin
        hold_valid <= 1'b0;
        if (!stall_in)
          iw_out <= NOP_IW;
      end else if (jmp_en_in) begin
        // imem_req is low here, so this is the only fetch_pc update this cycle.
        fetch_pc   <= {jmp_addr_in[31:2], 2'b00};
        hold_valid <= 1'b0;
        iw_out     <= NOP_IW;
      end else if (stall_in) begin
        if (req_valid) begin
          hold_valid <= 1'b1;
          hold_pc    <= req_pc;
          hold_iw    <= imem_rdata;
        end
      end else begin
        hold_valid <= 1'b0;
        pc_out     <= load_pc;
        iw_out     <= load_iw;
        if (load_en && load_iw == EBREAK_IW)
          halted <= 1'b1;
      end
    end
  end

endmodule
